// File: rtl/serv_uart_pkg.sv
// Shared types and constants for the SERV memory-mapped UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serv_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Word offsets on the data bus (adr[3:2]); offset 3 is reserved.
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  // STATUS register layout.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 5;

endpackage

// File: rtl/serv_uart_fifo.sv
// Byte FIFO between the bus write port and the serialiser.
// Latency: a push is visible (empty=0, dout valid) after the push edge.
// Backpressure: a push while full is dropped unless a pop happens on the same edge.
// Ports: push/din write side, pop/dout read side, full/empty/count status.
module serv_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the SERV dbus with TX FIFO, baud divisor and idle IRQ.
// Latency: bus ack one cycle after cyc; start bit on o_tx two edges after a push into an idle UART.
// Backpressure: none on the bus; bytes pushed into a full FIFO are dropped and flagged in STATUS.ovf.
// Ports: clk/i_rst, dbus slave (i_wb_adr/dat/sel/we/cyc, o_wb_rdt/ack), o_tx serial line, o_irq idle level.
module serv_uart_tx
  import serv_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd233
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_t   state, state_d;
  logic [15:0]   baud_cnt, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shift, shift_d;
  logic [15:0]   div;
  logic          ovf;
  logic          tx_d;
  logic          bit_end;

  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          accept;
  logic          wr_txdata;
  logic          wr_div;
  logic          rd_status;
  logic          push_ok;
  logic          empty_nxt;
  logic [31:0]   rdt_d;

  // Upper data lanes have no register bits behind them.
  logic          unused_ok;
  assign unused_ok = &{1'b0, i_wb_dat[31:16], i_wb_sel[3:2]};

  // Every side effect is gated on the accept edge so a held cyc acts once per ack.
  assign accept    = i_wb_cyc && !o_wb_ack;
  assign wr_txdata = accept && i_wb_we && (i_wb_adr == REG_TXDATA) && i_wb_sel[0];
  assign wr_div    = accept && i_wb_we && (i_wb_adr == REG_DIV);
  assign rd_status = accept && !i_wb_we && (i_wb_adr == REG_STATUS);

  serv_uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (i_rst),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (i_wb_dat[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Mirror of the FIFO's accept rule; fifo_pop is only raised when non-empty.
  assign push_ok   = wr_txdata && (!fifo_full || fifo_pop);
  assign empty_nxt = ((fifo_count == '0) && !push_ok) ||
                     ((fifo_count == CW'(1)) && fifo_pop && !push_ok);

  assign bit_end = (baud_cnt == '0);

  always_comb begin
    state_d  = state;
    baud_d   = baud_cnt;
    bit_d    = bit_idx;
    shift_d  = shift;
    fifo_pop = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = div;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          baud_d  = div;
        end else begin
          baud_d = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift[7:1]};
          baud_d  = div;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_idx + 3'd1;
          end
        end else begin
          baud_d = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            baud_d   = div;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_cnt - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level derived from the next state so o_tx can be a plain flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rdt_d = '0;
    if (accept && !i_wb_we) begin
      case (i_wb_adr)
        REG_STATUS: begin
          rdt_d[STAT_BUSY]  = (state != IDLE);
          rdt_d[STAT_FULL]  = fifo_full;
          rdt_d[STAT_EMPTY] = fifo_empty;
          rdt_d[STAT_OVF]   = ovf;
          rdt_d[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
        end
        REG_DIV:  rdt_d[15:0] = div;
        default:  rdt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      div      <= DEFAULT_DIV;
      ovf      <= 1'b0;
      o_tx     <= 1'b1;
      o_irq    <= 1'b1;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shift    <= shift_d;
      o_tx     <= tx_d;
      o_irq    <= (state_d == IDLE) && empty_nxt;
      o_wb_ack <= accept;
      o_wb_rdt <= rdt_d;
      if (wr_div && i_wb_sel[0]) div[7:0]  <= i_wb_dat[7:0];
      if (wr_div && i_wb_sel[1]) div[15:8] <= i_wb_dat[15:8];
      // STATUS read returns the old ovf (captured in rdt_d) and clears it.
      if (rd_status) begin
        ovf <= 1'b0;
      end else if (wr_txdata && fifo_full && !fifo_pop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
